// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants, enable bundle type and the duty compare helper
// for the PWM peripheral. Imported by pwm_timebase and pwm_peripheral.
package pwm_pkg;

   localparam int                   PWM_CNT_W       = 8;
   localparam logic [PWM_CNT_W-1:0] DUTY_FULL       = 8'hFF;
   localparam int                   NUM_OUT         = 16;
   localparam int                   DEFAULT_CLK_DIV = 13;

   // Enable registers as seen by the output stage.
   typedef struct packed {
      logic [NUM_OUT-1:0] out_en;
      logic [NUM_OUT-1:0] pwm_en;
   } pwm_en_t;

   // Full-scale duty is forced high so 0xFF never shows a one-step low
   // pulse at counter==255.
   function automatic logic pwm_compare(input logic [PWM_CNT_W-1:0] cnt,
                                        input logic [PWM_CNT_W-1:0] duty);
      return (duty == DUTY_FULL) ? 1'b1 : (cnt < duty);
   endfunction

endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: prescaler plus 8-bit period counter.
//   clk, rst_n   : system clock, synchronous active-low reset
//   counter      : period position, advances once per CLK_DIV clocks
//   tick         : prescaler terminal count (counter advances on this edge)
//   period_wrap  : tick while counter==255, i.e. the period boundary edge
module pwm_timebase
   import pwm_pkg::*;
#(
   parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic [PWM_CNT_W-1:0] counter,
   output logic                 tick,
   output logic                 period_wrap
);

   logic [7:0] prescaler;

   assign tick        = (prescaler == 8'(CLK_DIV - 1));
   assign period_wrap = tick && (counter == '1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prescaler <= '0;
         counter   <= '0;
      end else begin
         if (tick) prescaler <= '0;
         else      prescaler <= prescaler + 8'd1;
         // 255 -> 0 wrap is the natural overflow of the 8-bit counter
         if (tick) counter <= counter + PWM_CNT_W'(1);
      end
   end

endmodule

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: drives 16 user outputs as static low, static high or PWM
// from the register-bank enables and duty value.
//   clk, rst_n        : system clock, synchronous active-low reset
//   en_reg_out_*      : per-output enable (0 forces the output low)
//   en_reg_pwm_*      : per-output PWM select (0 = static high when enabled)
//   pwm_duty_cycle    : requested duty, captured at each period boundary
//   out               : registered user outputs
//   period_start      : one-clk pulse on the first clk of each period
module pwm_peripheral
   import pwm_pkg::*;
#(
   parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [7:0]         en_reg_out_7_0,
   input  logic [7:0]         en_reg_out_15_8,
   input  logic [7:0]         en_reg_pwm_7_0,
   input  logic [7:0]         en_reg_pwm_15_8,
   input  logic [7:0]         pwm_duty_cycle,
   output logic [NUM_OUT-1:0] out,
   output logic               period_start
);

   pwm_en_t              en;
   logic [PWM_CNT_W-1:0] counter;
   logic [PWM_CNT_W-1:0] duty_shadow;
   logic                 period_wrap;
   logic                 tick_unused;   // top works at period granularity only
   logic                 pwm_raw;
   logic [NUM_OUT-1:0]   out_next;

   assign en.out_en = {en_reg_out_15_8, en_reg_out_7_0};
   assign en.pwm_en = {en_reg_pwm_15_8, en_reg_pwm_7_0};

   pwm_timebase #(.CLK_DIV(CLK_DIV)) u_timebase (
      .clk         (clk),
      .rst_n       (rst_n),
      .counter     (counter),
      .tick        (tick_unused),
      .period_wrap (period_wrap)
   );

   assign pwm_raw = pwm_compare(counter, duty_shadow);

   // Output enable dominates the PWM select.
   for (genvar i = 0; i < NUM_OUT; i++) begin : g_out
      assign out_next[i] = en.out_en[i] ? (en.pwm_en[i] ? pwm_raw : 1'b1) : 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         duty_shadow  <= '0;
         out          <= '0;
         period_start <= 1'b0;
      end else begin
         out          <= out_next;
         period_start <= period_wrap;
         // Shadow only reloads at the boundary so a mid-period write can
         // never shorten or split the pulse already in progress.
         if (period_wrap) duty_shadow <= pwm_duty_cycle;
      end
   end

endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
Downstream consumer of the SPI register bank. Takes the five 8-bit control registers (output enables, PWM-mode enables, duty cycle) and drives 16 user outputs, each either static low, static high or PWM-modulated. Contains the prescaler, the 8-bit period counter and a period-aligned duty shadow register, so duty updates never produce glitch pulses.

Parameters:
CLK_DIV, 13, prescaler terminal count; one counter step every CLK_DIV clk cycles (10 MHz / 13 / 256 ≈ 3.0 kHz PWM). Legal range 1..255.
NUM_OUT, 16, number of driven outputs; fixed at 16 for this revision.

Ports:
clk  input  1  system clock, single clock domain
rst_n  input  1  synchronous active-low reset
en_reg_out_7_0  input  8  output enable, bits 7:0
en_reg_out_15_8  input  8  output enable, bits 15:8
en_reg_pwm_7_0  input  8  PWM-mode select, bits 7:0
en_reg_pwm_15_8  input  8  PWM-mode select, bits 15:8
pwm_duty_cycle  input  8  requested duty, 0x00..0xFF
out  output  16  registered user outputs
period_start  output  1  one-clk pulse on the first clk of each PWM period

Behaviour:
- Reset: one clock; reset is synchronous and active-low, sampled on posedge clk only. While rst_n=0: prescaler=0, counter=0, duty_shadow=0x00, out=16'h0000, period_start=0.
- Prescaler: counts 0..CLK_DIV-1, wraps to 0. tick=1 when prescaler==CLK_DIV-1. CLK_DIV=1 gives tick every cycle.
- Counter: 8-bit, increments on tick, 255 -> 0 natural wrap. Period = 256*CLK_DIV clk cycles.
- Period boundary = tick while counter==255. On that edge: counter->0, duty_shadow<=pwm_duty_cycle, period_start<=1 for exactly one cycle.
- First period after reset: duty_shadow=0 until first boundary; no period_start pulse at reset release.
- pwm_raw = (duty_shadow==0xFF) ? 1 : (counter < duty_shadow). Result: 0x00 always low, 0xFF always high (no one-step low), 0x80 high for counter 0..127.
- Per bit i: out[i] <= en_out[i] ? (en_pwm[i] ? pwm_raw : 1) : 0, where en_out = {en_reg_out_15_8, en_reg_out_7_0} and en_pwm likewise.
- Latency: out registered, one clk after counter/shadow/enable change. Enable changes are not shadowed; they take effect on the next clk edge. Duty changes take effect only at the next period boundary.
- Simultaneous events: a duty write coinciding with the boundary edge samples the new value. Enable and boundary in the same cycle are applied independently.
- en_pwm[i]=1 with en_out[i]=0 gives 0; the output enable dominates.
- Reset asserted mid-period: all state cleared on that edge. The period restarts from counter=0 after release.
- All outputs are held constant between ticks except out reacting to enables.

Decomposition:
- Package pwm_pkg: PWM_CNT_W=8, DUTY_FULL=8'hFF, NUM_OUT=16, DEFAULT_CLK_DIV=13.
- Sub-module pwm_timebase: prescaler plus counter. Outputs counter[7:0], tick and period_wrap. The top-level holds duty_shadow, compare and output mux.

Test Plan:
- Reset: hold rst_n=0 for 5 clk with all inputs 0xFF -> out=0x0000, period_start=0. After release, out=0xFFFF after the first boundary plus 1 clk.
- Static modes: en_out=0x00FF, en_pwm=0x0000 -> out=0x00FF one clk later. Then en_out=0xFF00 -> out=0xFF00.
- Duty 0x80, en_out=en_pwm=0xFFFF, CLK_DIV=13 -> each out bit high 1664 clk, low 1664 clk, period 3328 clk, period_start spaced 3328 clk.
- Extremes: duty 0x00 -> out stays 0x0000 over 2 full periods. Duty 0xFF -> out stays 0xFFFF, no low cycle.
- Mid-period duty change 0x40 -> 0xC0 at counter=100 -> current period ends with high-time 64 steps, next period high-time 192 steps, no extra edge.
- Reset mid-period at counter=200 -> out=0 on that edge. After release, the counter restarts from 0 and the next period_start arrives 3328 clk later.
